// File: rtl/fpu_pkg.sv
// Shared FPU definitions: writeback source encoding and IEEE exception flag layout.
package fpu_pkg;

  typedef enum logic [1:0] {
    SRC_ADD  = 2'b00,
    SRC_MUL  = 2'b01,
    SRC_DIV  = 2'b10,
    SRC_NONE = 2'b11
  } src_e;

  localparam int unsigned NUM_SRC    = 3;
  localparam int unsigned FLAG_WIDTH = 5;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

endpackage

// File: rtl/fpu_wb_arbiter_if.sv
// Writeback arbiter bus: three producer result ports plus the single registered writeback port.
interface fpu_wb_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FLAG_WIDTH = 5
);

  logic [2:0]            in_valid;
  logic [2:0]            in_ready;
  logic [DATA_WIDTH-1:0] in0_data;
  logic [DATA_WIDTH-1:0] in1_data;
  logic [DATA_WIDTH-1:0] in2_data;
  logic [FLAG_WIDTH-1:0] in0_flags;
  logic [FLAG_WIDTH-1:0] in1_flags;
  logic [FLAG_WIDTH-1:0] in2_flags;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [FLAG_WIDTH-1:0] out_flags;
  logic [1:0]            out_src;

  // The arbiter itself.
  modport slave (
    input  in_valid, in0_data, in1_data, in2_data, in0_flags, in1_flags, in2_flags, out_ready,
    output in_ready, out_valid, out_data, out_flags, out_src
  );

  // Execution units and writeback consumer.
  modport master (
    output in_valid, in0_data, in1_data, in2_data, in0_flags, in1_flags, in2_flags, out_ready,
    input  in_ready, out_valid, out_data, out_flags, out_src
  );

endinterface

// File: rtl/fpu_wb_arbiter_mux3.sv
// 3-to-1 select using the source encoding 2'b00/01/10; 2'b11 yields zero.
module fpu_wb_arbiter_mux3 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/fpu_wb_arbiter.sv
// Round-robin arbiter sharing one registered FPU writeback port between add, mul and div units.
module fpu_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FLAG_WIDTH = 5
) (
  input logic             clk,
  input logic             rst_n,
  fpu_wb_arbiter_if.slave bus
);

  import fpu_pkg::src_e;
  import fpu_pkg::SRC_ADD;
  import fpu_pkg::SRC_MUL;
  import fpu_pkg::SRC_DIV;
  import fpu_pkg::SRC_NONE;
  import fpu_pkg::NUM_SRC;

  typedef enum logic {StEmpty, StFull} state_e;

  state_e                state_q, state_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, mux_data;
  logic [FLAG_WIDTH-1:0] flags_q, flags_d, mux_flags;
  src_e                  src_q, src_d, sel;
  logic                  load_en;
  logic                  xfer;

  // First valid source scanning ptr, ptr+1, ptr+2 (mod 3).
  function automatic src_e rr_pick(input logic [NUM_SRC-1:0] valid, input logic [1:0] ptr);
    src_e       pick;
    logic       found;
    logic [2:0] sum;
    logic [1:0] idx;
    pick  = SRC_NONE;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, ptr} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      idx = sum[1:0];
      if (!found && valid[idx]) begin
        pick  = src_e'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign sel     = rr_pick(bus.in_valid, rr_ptr_q);
  assign load_en = (state_q == StEmpty) || bus.out_ready;
  assign xfer    = rst_n && load_en && (sel != SRC_NONE);

  assign bus.in_ready = {xfer && (sel == SRC_DIV), xfer && (sel == SRC_MUL), xfer && (sel == SRC_ADD)};

  fpu_wb_arbiter_mux3 #(
    .WIDTH(DATA_WIDTH)
  ) u_data_mux (
    .sel(sel),
    .d0 (bus.in0_data),
    .d1 (bus.in1_data),
    .d2 (bus.in2_data),
    .y  (mux_data)
  );

  fpu_wb_arbiter_mux3 #(
    .WIDTH(FLAG_WIDTH)
  ) u_flags_mux (
    .sel(sel),
    .d0 (bus.in0_flags),
    .d1 (bus.in1_flags),
    .d2 (bus.in2_flags),
    .y  (mux_flags)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    flags_d  = flags_q;
    src_d    = src_q;

    unique case (state_q)
      StEmpty: begin
        if (xfer) state_d = StFull;
      end
      StFull: begin
        // Drain without a refill empties the slot; data/flags keep their last value.
        if (!xfer && bus.out_ready) begin
          state_d = StEmpty;
          src_d   = SRC_NONE;
        end
      end
      default: state_d = StEmpty;
    endcase

    if (xfer) begin
      data_d   = mux_data;
      flags_d  = mux_flags;
      src_d    = sel;
      rr_ptr_d = (sel == SRC_DIV) ? 2'd0 : 2'(sel) + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      rr_ptr_q <= 2'd0;
      data_q   <= '0;
      flags_q  <= '0;
      src_q    <= SRC_NONE;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      flags_q  <= flags_d;
      src_q    <= src_d;
    end
  end

  assign bus.out_valid = (state_q == StFull);
  assign bus.out_data  = data_q;
  assign bus.out_flags = flags_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Directed and randomized bench for fpu_wb_arbiter against a cycle-level reference model.
module tb_fpu_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned FW = 5;

  localparam logic [DW-1:0] D0 = 32'hA0A0_0000;
  localparam logic [DW-1:0] D1 = 32'h3F80_0000;
  localparam logic [DW-1:0] D2 = 32'hC2C2_0002;
  localparam logic [FW-1:0] F0 = 5'b10000;
  localparam logic [FW-1:0] F1 = 5'b00001;
  localparam logic [FW-1:0] F2 = 5'b01010;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_wb_arbiter_if #(.DATA_WIDTH(DW), .FLAG_WIDTH(FW)) bus ();

  fpu_wb_arbiter #(
    .DATA_WIDTH(DW),
    .FLAG_WIDTH(FW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: contents of the single writeback slot and the rotating priority start.
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic [FW-1:0] m_flags = '0;
  logic [1:0]    m_src   = 2'b11;
  int            m_ptr   = 0;

  function automatic int pick(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check grant mid-cycle, advance model at the edge, check outputs just after it.
  task automatic cycle();
    logic       load;
    int         win;
    logic [2:0] er;
    #3;
    load = !m_valid || bus.out_ready;
    win  = pick(bus.in_valid, m_ptr);
    er   = 3'b000;
    if (rst_n && load && win >= 0) er = 3'(1 << win);
    chk("in_ready", 64'(bus.in_ready), 64'(er));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_flags = '0;
      m_src   = 2'b11;
      m_ptr   = 0;
    end else if (er != 3'b000) begin
      m_valid = 1'b1;
      m_src   = 2'(win);
      m_data  = (win == 0) ? bus.in0_data : (win == 1) ? bus.in1_data : bus.in2_data;
      m_flags = (win == 0) ? bus.in0_flags : (win == 1) ? bus.in1_flags : bus.in2_flags;
      m_ptr   = (win + 1) % 3;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
      m_src   = 2'b11;
    end
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("out_src", 64'(bus.out_src), 64'(m_src));
    chk("out_data", 64'(bus.out_data), 64'(m_data));
    chk("out_flags", 64'(bus.out_flags), 64'(m_flags));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 3'b000;
    bus.out_ready = 1'b0;
    bus.in0_data  = D0;
    bus.in1_data  = D1;
    bus.in2_data  = D2;
    bus.in0_flags = F0;
    bus.in1_flags = F1;
    bus.in2_flags = F2;

    // Reset
    repeat (2) cycle();
    chk("rst_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("rst_src", 64'(bus.out_src), 64'(2'b11));
    chk("rst_data", 64'(bus.out_data), 64'(32'h0));
    rst_n = 1'b1;

    // Single source
    bus.in_valid  = 3'b010;
    bus.out_ready = 1'b1;
    cycle();
    chk("single_valid", 64'(bus.out_valid), 64'(1'b1));
    chk("single_data", 64'(bus.out_data), 64'(32'h3F80_0000));
    chk("single_flags", 64'(bus.out_flags), 64'(5'b00001));
    chk("single_src", 64'(bus.out_src), 64'(2'b01));

    // Drain only
    bus.in_valid = 3'b000;
    cycle();
    chk("drain_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("drain_src", 64'(bus.out_src), 64'(2'b11));
    chk("drain_hold", 64'(bus.out_data), 64'(32'h3F80_0000));

    // Reset mid-operation with a held, stalled entry
    bus.in_valid  = 3'b111;
    bus.out_ready = 1'b0;
    cycle();
    chk("held_src", 64'(bus.out_src), 64'(2'b10));
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("midrst_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("midrst_src", 64'(bus.out_src), 64'(2'b11));
    chk("midrst_data", 64'(bus.out_data), 64'(32'h0));
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;

    // All valid, full throughput: 0,1,2,0,1,2 with no bubble
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_src", 64'(bus.out_src), 64'(k % 3));
      chk("rr_valid", 64'(bus.out_valid), 64'(1'b1));
    end

    // Backpressure
    bus.in_valid = 3'b000;
    cycle();
    bus.in_valid = 3'b111;
    cycle();
    chk("bp_first", 64'(bus.out_src), 64'(2'b00));
    bus.out_ready = 1'b0;
    repeat (4) begin
      cycle();
      chk("bp_data", 64'(bus.out_data), 64'(D0));
      chk("bp_src", 64'(bus.out_src), 64'(2'b00));
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_release", 64'(bus.out_src), 64'(2'b01));

    // Pointer wrap after granting source 2
    bus.in_valid = 3'b100;
    cycle();
    chk("wrap_2", 64'(bus.out_src), 64'(2'b10));
    bus.in_valid = 3'b011;
    cycle();
    chk("wrap_0", 64'(bus.out_src), 64'(2'b00));
    cycle();
    chk("wrap_1", 64'(bus.out_src), 64'(2'b01));

    // Drain only, again from a full slot
    bus.in_valid = 3'b000;
    cycle();
    chk("drain2_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("drain2_src", 64'(bus.out_src), 64'(2'b11));

    // Randomized traffic with occasional stalls and resets
    repeat (400) begin
      bus.in_valid  = 3'($urandom_range(0, 7));
      bus.in0_data  = $urandom;
      bus.in1_data  = $urandom;
      bus.in2_data  = $urandom;
      bus.in0_flags = 5'($urandom_range(0, 31));
      bus.in1_flags = 5'($urandom_range(0, 31));
      bus.in2_flags = 5'($urandom_range(0, 31));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst_n         = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
